// File: rtl/nnoc_fp_pkg.sv
// Shared floating-point types and helpers for the BF16 MAC datapath.
// Provides FP32/BF16 packed structs, width constants and the FP32 -> BF16
// round-to-nearest-even conversion used by the drain stage.
package nnoc_fp_pkg;

    localparam int unsigned FP32_EXP_W = 8;
    localparam int unsigned FP32_MAN_W = 23;
    localparam int unsigned BF16_MAN_W = 7;

    localparam logic [BF16_MAN_W-1:0] BF16_QNAN_MANT = 7'h40;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] mant;
    } fp32_t;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [BF16_MAN_W-1:0] mant;
    } bf16_t;

    typedef struct packed {
        bf16_t val;
        logic  ovf;  // finite input rounded up to +/-Inf
    } bf16_rnd_t;

    function automatic bf16_rnd_t fp32_to_bf16_rne(fp32_t f, bit ftz);
        bf16_rnd_t   res;
        logic [31:0] raw;
        logic [15:0] r;
        logic        inc;
        raw     = f;
        res.ovf = 1'b0;
        // Round up when above half, or exactly half with an odd kept LSB.
        inc = raw[15] & ((|raw[14:0]) | raw[16]);
        // Finite inputs have raw[30:16] <= 16'h7F7F, so the add never reaches the sign.
        r   = raw[31:16] + {15'd0, inc};
        if (f.exp == '1) begin
            if (f.mant != '0) begin
                res.val = {f.sign, 8'hFF, BF16_QNAN_MANT};
            end else begin
                res.val = raw[31:16];
            end
        end else if ((f.exp == '0) && ftz) begin
            res.val = {f.sign, 15'd0};
        end else begin
            res.val = r;
            res.ovf = (r[14:7] == 8'hFF);
        end
        return res;
    endfunction

endpackage

// File: rtl/fp32_to_bf16_round.sv
// Stage 1 of the result packer: registers the BF16-rounded value of each
// accepted FP32 result and keeps the saturating overflow count.
//  clk, rst            clock, synchronous active-high reset
//  in_valid/in_ready   upstream handshake; in_data FP32, in_last end of tile
//  out_valid/out_ready handshake towards the lane assembler
//  out_data/out_last   rounded BF16 value and its last flag
//  ovf_count           saturating count of finite inputs rounded to +/-Inf
module fp32_to_bf16_round
    import nnoc_fp_pkg::*;
#(
    parameter int unsigned FTZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output bf16_t       out_data,
    output logic        out_last,
    output logic [15:0] ovf_count
);

    bf16_rnd_t rnd;

    assign rnd = fp32_to_bf16_rne(fp32_t'(in_data), FTZ != 0);

    // The register may refill in the same cycle it drains; never looks at in_valid.
    assign in_ready = !rst && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            ovf_count <= '0;
        end else begin
            if (in_ready) begin
                out_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                out_data <= rnd.val;
                out_last <= in_last;
                if (rnd.ovf && (ovf_count != 16'hFFFF)) begin
                    ovf_count <= ovf_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bf16_result_packer.sv
// Drain stage of the BF16 MAC datapath: rounds FP32 results to BF16 and packs
// PACK lanes per output word.
//  clk, rst                      clock, synchronous active-high reset
//  in_valid/in_ready/in_data     FP32 result stream; in_last closes the current word
//  out_valid/out_ready           packed word handshake
//  out_data                      PACK BF16 lanes, lane 0 in bits [15:0]
//  out_keep                      per-lane valid mask
//  out_last                      word holds the tile's last result
//  ovf_count                     saturating count of finite inputs rounded to +/-Inf
module bf16_result_packer #(
    parameter int unsigned PACK = 2,
    parameter int unsigned FTZ  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [16*PACK-1:0] out_data,
    output logic [PACK-1:0]    out_keep,
    output logic               out_last,
    output logic [15:0]        ovf_count
);

    import nnoc_fp_pkg::*;

    localparam int unsigned CntW = (PACK > 1) ? $clog2(PACK) : 1;

    bf16_t s1_data;
    logic  s1_valid;
    logic  s1_ready;
    logic  s1_last;

    fp32_to_bf16_round #(
        .FTZ(FTZ)
    ) u_round (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(s1_valid),
        .out_ready(s1_ready),
        .out_data (s1_data),
        .out_last (s1_last),
        .ovf_count(ovf_count)
    );

    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [16*PACK-1:0]   acc_q, acc_d, word;
    logic [PACK-1:0]      keep_q, keep_d, word_keep;
    logic                 out_free;
    logic                 lane_done;
    logic                 take;
    logic                 handoff;

    // Output register can take a word if empty or being drained this cycle.
    assign out_free  = !out_valid || out_ready;
    assign lane_done = s1_last || (cnt_q == CntW'(PACK - 1));
    // Only a word-completing lane needs the output register; other lanes always fit.
    assign s1_ready  = !lane_done || out_free;
    assign take      = s1_valid && s1_ready;
    assign handoff   = take && lane_done;

    always_comb begin
        word      = acc_q;
        word_keep = keep_q;
        for (int i = 0; i < PACK; i++) begin
            if (cnt_q == CntW'(i)) begin
                word[16*i +: 16] = s1_data;
                word_keep[i]     = 1'b1;
            end
        end
        acc_d  = acc_q;
        keep_d = keep_q;
        cnt_d  = cnt_q;
        if (handoff) begin
            acc_d  = '0;
            keep_d = '0;
            cnt_d  = '0;
        end else if (take) begin
            acc_d  = word;
            keep_d = word_keep;
            cnt_d  = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            keep_q    <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            keep_q <= keep_d;
            cnt_q  <= cnt_d;
            if (handoff) begin
                out_valid <= 1'b1;
                out_data  <= word;
                out_keep  <= word_keep;
                out_last  <= s1_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
